if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter XLEN, default 32, instruction/address width.
REQ-002 Parameter DEPTH, default 4, prefetch-buffer entries; power of two, >=2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 Parameter BUBBLE, default all-ones (32'hFFFF_FFFF at XLEN=32), filler instruction word.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 redirect_valid  in  1  taken branch/jump; flush and refetch.
REQ-008 redirect_pc  in  XLEN  redirect target.
REQ-009 imem_req_valid  out  1  fetch request.
REQ-010 imem_req_ready  in  1  memory accepts request.
REQ-011 imem_req_addr  out  XLEN  fetch address.
REQ-012 imem_rsp_valid  in  1  in-order response strobe.
REQ-013 imem_rsp_data  in  XLEN  instruction word.
REQ-014 id_valid  out  1  instruction available to decode.
REQ-015 id_ready  in  1  decode accepts (deasserted = stall).
REQ-016 id_inst, id_pc, id_npc  out  XLEN each  instruction, its PC, PC+4.
REQ-017 id_prev_inst  out  XLEN  last instruction accepted by decode.
REQ-018 occupancy  out  clog2(DEPTH)+1  valid buffer entries.

Function
REQ-019 Request issued when credits = occupancy + inflight < DEPTH and redirect_valid low; transfer on imem_req_valid & imem_req_ready.
REQ-020 imem_req_addr = fetch_pc; fetch_pc += 4 on each transfer, modulo 2^XLEN (wrap, no flag).
REQ-021 inflight +1 per transfer, -1 per imem_rsp_valid; both same cycle -> unchanged.
REQ-022 Each non-discarded response pushes {data, pc} into FIFO tail; pc from an in-order tag queue of issued addresses.
REQ-023 id_valid = occupancy != 0; id_inst/id_pc = FIFO head; id_npc = id_pc + 4; pop on id_valid & id_ready.
REQ-024 Push and pop same cycle: occupancy unchanged; empty FIFO does not bypass (min latency response->id_valid = 1 cycle).
REQ-025 Credit rule guarantees no push when full; response arriving with FIFO full is a protocol error and is ignored.
REQ-026 redirect_valid (priority over all): next cycle occupancy = 0, fetch_pc = redirect_pc, discard = inflight (including a same-cycle transfer), no pop/push that cycle, id_prev_inst unchanged.
REQ-027 While discard != 0, responses decrement discard and are dropped; redirect during discard reloads discard with current inflight.
REQ-028 id_prev_inst loads id_inst on each pop; otherwise holds.
REQ-029 States: RUN (normal) and DRAIN (discard != 0); RUN->DRAIN on redirect with inflight>0; DRAIN->RUN when discard reaches 0; requests permitted in DRAIN.

Reset
REQ-030 On rst: fetch_pc = RESET_PC, occupancy = inflight = discard = 0, state RUN, id_prev_inst = BUBBLE, imem_req_valid = 0, id_valid = 0.
REQ-031 id_inst = BUBBLE and id_pc = RESET_PC whenever id_valid = 0.
REQ-032 Reset mid-operation abandons inflight responses; responses after reset release are the memory's obligation to suppress.
REQ-033 First request issued no earlier than the first rising edge after rst deasserts.

Structure
REQ-034 Shared package holds BUBBLE, PC increment (4), RESET_PC default and the fetch-entry struct {inst, pc}.
REQ-035 One sub-module: fetch_fifo (parametrised DEPTH x entry, push/pop/flush, count), instantiated for data FIFO and address tag queue.

Verification
REQ-036 Reset, memory ready, 1-cycle response, id_ready=1 -> addresses 0,4,8,...; id_inst sequence matches memory; id_prev_inst = BUBBLE until first pop.
REQ-037 id_ready=0 for 10 cycles -> occupancy saturates at 4, imem_req_valid low, inflight 0; release -> 4 pops, no loss/duplication.
REQ-038 Redirect to 0x100 with 2 inflight, 3-cycle latency -> 2 responses dropped, next id_pc = 0x100, id_prev_inst unchanged.
REQ-039 Back-to-back redirects 0x200 then 0x300 -> only 0x300 stream delivered.
REQ-040 fetch_pc at 0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-041 rst asserted with full FIFO -> all outputs at REQ-030/031 values same cycle.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
package if_prefetch_pkg;
   localparam int          IFP_XLEN     = 32;
   localparam int unsigned IFP_PC_INC   = 4;
   localparam logic [63:0] IFP_RESET_PC = '0;
   localparam logic [63:0] IFP_BUBBLE   = '1;

   typedef struct packed {
      logic [IFP_XLEN-1:0] inst;
      logic [IFP_XLEN-1:0] pc;
   } fetch_entry_t;

   typedef enum logic {ST_RUN, ST_DRAIN} fetch_state_t;
endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// Small circular FIFO with synchronous flush; used for fetched words and for the issued-address tags.
module fetch_fifo #(
   parameter  int W     = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] head,
   output logic [AW:0]  count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          wr_en, rd_en;

   // Guard against over/underflow even if a caller breaks the protocol.
   assign wr_en = push && (count != (AW+1)'(DEPTH));
   assign rd_en = pop && (count != '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (rd_en && !wr_en) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !flush) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: credit-limited requests, in-order responses buffered for decode,
// redirect flushes the buffer and drops responses still owed for the old stream.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter  int              XLEN     = IFP_XLEN,
   parameter  int              DEPTH    = 4,
   parameter  logic [XLEN-1:0] RESET_PC = XLEN'(IFP_RESET_PC),
   parameter  logic [XLEN-1:0] BUBBLE   = XLEN'(IFP_BUBBLE),
   localparam int              CW       = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_inst,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_npc,
   output logic [XLEN-1:0] id_prev_inst,
   output logic [CW-1:0]   occupancy
);
   fetch_state_t      state, state_nxt;
   logic [XLEN-1:0]   fetch_pc, tag_pc;
   logic [CW-1:0]     inflight, inflight_nxt, discard, discard_nxt, tag_count;
   logic [CW:0]       credits;
   logic [2*XLEN-1:0] head;
   logic              started, req_fire, rsp_cnt, rsp_keep, data_push, data_pop;

   // started holds off the first request until one edge after reset release.
   assign credits        = {1'b0, occupancy} + {1'b0, inflight};
   assign imem_req_valid = started && !redirect_valid && (credits < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_cnt        = imem_rsp_valid && (inflight != '0);
   assign inflight_nxt   = inflight + CW'(req_fire) - CW'(rsp_cnt);

   assign rsp_keep  = rsp_cnt && !redirect_valid && (state == ST_RUN) && (tag_count != '0);
   assign data_push = rsp_keep && (occupancy != CW'(DEPTH));
   assign data_pop  = id_valid && id_ready && !redirect_valid;

   assign id_valid = (occupancy != '0);
   assign id_inst  = id_valid ? head[2*XLEN-1:XLEN] : BUBBLE;
   assign id_pc    = id_valid ? head[XLEN-1:0] : RESET_PC;
   assign id_npc   = id_pc + XLEN'(IFP_PC_INC);

   // Redirect reloads discard with whatever is still owed after this cycle.
   always_comb begin
      state_nxt   = state;
      discard_nxt = discard;
      if (redirect_valid) begin
         discard_nxt = inflight_nxt;
         state_nxt   = (inflight_nxt != '0) ? ST_DRAIN : ST_RUN;
      end else if (state == ST_DRAIN && rsp_cnt) begin
         discard_nxt = discard - 1'b1;
         if (discard == CW'(1)) state_nxt = ST_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_RUN;
         discard      <= '0;
         inflight     <= '0;
         fetch_pc     <= RESET_PC;
         started      <= 1'b0;
         id_prev_inst <= BUBBLE;
      end else begin
         state    <= state_nxt;
         discard  <= discard_nxt;
         inflight <= inflight_nxt;
         started  <= 1'b1;
         if (redirect_valid) fetch_pc <= redirect_pc;
         else if (req_fire)  fetch_pc <= fetch_pc + XLEN'(IFP_PC_INC);
         if (data_pop) id_prev_inst <= id_inst;
      end
   end

   // Tags are flushed on redirect; dropped responses never consult them.
   fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag (
      .clk       (clk),
      .rst       (rst),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (rsp_keep),
      .flush     (redirect_valid),
      .head      (tag_pc),
      .count     (tag_count)
   );

   fetch_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_data (
      .clk       (clk),
      .rst       (rst),
      .push      (data_push),
      .push_data ({imem_rsp_data, tag_pc}),
      .pop       (data_pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (occupancy)
   );
endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: driver queues expectations, one negedge process models memory and checks.
module tb_if_prefetch;
   localparam logic [31:0] BUB = 32'hFFFF_FFFF;

   logic        clk, rst, redirect_valid, imem_req_valid, imem_req_ready;
   logic        imem_rsp_valid, id_valid, id_ready;
   logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data;
   logic [31:0] id_inst, id_pc, id_npc, id_prev_inst;
   logic [2:0]  occupancy;

   if_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .BUBBLE(BUB)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
      .id_inst(id_inst), .id_pc(id_pc), .id_npc(id_npc), .id_prev_inst(id_prev_inst),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] inst; logic [31:0] pc; logic [31:0] prev; } exp_t;
   typedef struct { int due; logic [31:0] addr; } mreq_t;

   exp_t        exq[$];
   int          snq[$];   // 0: reset values, 1: saturated, 2: scoreboard drained
   mreq_t       mq[$];
   int          errors = 0, checks = 0, cyc = 0, lat = 1;
   logic [31:0] exp_addr = 32'h0, exp_pc_next = 32'h0, prev_model = BUB;

   function automatic logic [31:0] inst_of(logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory model + monitor; sole owner of the counters.
   initial begin
      exp_t  e;
      mreq_t m;
      int    k;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         while (snq.size() != 0) begin
            k = snq.pop_front();
            if (k == 0) begin
               chk("rst_id_valid", 32'(id_valid), 32'd0);
               chk("rst_occupancy", 32'(occupancy), 32'd0);
               chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
               chk("rst_id_inst", id_inst, BUB);
               chk("rst_id_pc", id_pc, 32'h0);
               chk("rst_id_npc", id_npc, 32'h4);
               chk("rst_prev_inst", id_prev_inst, BUB);
            end else if (k == 1) begin
               chk("sat_occupancy", 32'(occupancy), 32'd4);
               chk("sat_req_valid", 32'(imem_req_valid), 32'd0);
               chk("sat_inflight", 32'(dut.inflight), 32'd0);
            end else begin
               chk("drain_remaining", 32'(exq.size()), 32'd0);
            end
         end
         if (rst) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            exp_addr = 32'h0;
         end else begin
            if (id_valid && id_ready && !redirect_valid) begin
               if (exq.size() == 0) begin
                  chk("unexpected_pop_pc", id_pc, 32'hxxxx_xxxx);
               end else begin
                  e = exq.pop_front();
                  chk("id_pc", id_pc, e.pc);
                  chk("id_inst", id_inst, e.inst);
                  chk("id_npc", id_npc, e.pc + 32'd4);
                  chk("id_prev_inst", id_prev_inst, e.prev);
               end
            end
            if (redirect_valid) begin
               exp_addr = redirect_pc;
            end else if (imem_req_valid && imem_req_ready) begin
               chk("req_addr", imem_req_addr, exp_addr);
               mq.push_back('{cyc + lat, imem_req_addr});
               exp_addr = exp_addr + 32'd4;
            end
            imem_rsp_valid = 1'b0;
            if (mq.size() != 0 && mq[0].due <= cyc) begin
               m = mq.pop_front();
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = inst_of(m.addr);
            end
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(int n);
      for (int i = 0; i < n; i++) begin
         exq.push_back('{inst_of(exp_pc_next), exp_pc_next, prev_model});
         prev_model  = inst_of(exp_pc_next);
         exp_pc_next = exp_pc_next + 32'd4;
      end
   endtask

   // Consume until the scoreboard is empty, bounded by maxc cycles.
   task automatic drain(int maxc);
      int c = 0;
      id_ready = 1'b1;
      while (exq.size() != 0 && c < maxc) begin
         step();
         c++;
      end
      id_ready = 1'b0;
      snq.push_back(2);
      step();
   endtask

   task automatic redirect(logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      exp_pc_next    = tgt;
   endtask

   initial begin
      rst = 1'b1; id_ready = 1'b0; imem_req_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      step(2);
      snq.push_back(0);
      step();
      rst = 1'b0;
      snq.push_back(0);
      step();

      // Straight-line stream from reset
      push_exp(6);
      drain(50);

      // Decode stall saturates the buffer, then release
      step(10);
      snq.push_back(1);
      step();
      imem_req_ready = 1'b0;
      push_exp(4);
      drain(50);

      // Redirect with two requests outstanding, 3-cycle latency
      lat = 3;
      imem_req_ready = 1'b1;
      step(2);
      imem_req_ready = 1'b0;
      redirect(32'h100);
      step();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      push_exp(3);
      drain(60);

      // Back-to-back redirects with a full buffer
      step(12);
      redirect(32'h200);
      step();
      redirect(32'h300);
      step();
      redirect_valid = 1'b0;
      push_exp(3);
      drain(60);

      // Address wrap at the top of the space
      lat = 1;
      redirect(32'hFFFF_FFF8);
      step();
      redirect_valid = 1'b0;
      push_exp(4);
      drain(60);

      // Reset with a full buffer, then restart
      step(10);
      rst = 1'b1;
      snq.push_back(0);
      step(2);
      rst = 1'b0;
      snq.push_back(0);
      step();
      exp_pc_next = 32'h0;
      prev_model  = BUB;
      push_exp(3);
      drain(50);

      step(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end
endmodule
